// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : RV32M multiply/divide unit. It uses 32-iteration shift-add
//                multiplication and restoring division. Optional macro
//                MULDIV_FAST_MUL_EN gives single-cycle combinational multiplies.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        FlushE,
    input  logic        StartE,
    input  logic [2:0]  Funct3E,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic [4:0]  RdE,
    output logic        StallE,
    output logic        DoneE,
    output logic [31:0] ResultE,
    output logic [4:0]  RdOutE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_MUL    = 3'd0;
    localparam logic [2:0] c_MULH   = 3'd1;
    localparam logic [2:0] c_MULHSU = 3'd2;
    localparam logic [2:0] c_DIV    = 3'd4;
    localparam logic [2:0] c_REM    = 3'd6;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_count;
    logic [2:0]  r_op;
    logic [31:0] r_operand;
    logic [63:0] r_acc;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_result;
    logic [4:0]  r_rd;

    logic        w_accept;
    logic        w_is_div;
    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic        w_special;
    logic [31:0] w_special_res;
    logic        w_fast;
    logic [31:0] w_fast_res;

    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_trial;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [63:0] w_div_next;
    logic [63:0] w_acc_next;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_final;

    // ---------------------------------------------------------------- decode
    assign w_accept   = (r_state == S_IDLE) && StartE && !FlushE;
    assign w_is_div   = Funct3E[2];
    assign w_a_signed = (Funct3E == c_MUL) || (Funct3E == c_MULH) || (Funct3E == c_MULHSU)
                        || (Funct3E == c_DIV) || (Funct3E == c_REM);
    assign w_b_signed = (Funct3E == c_MUL) || (Funct3E == c_MULH)
                        || (Funct3E == c_DIV) || (Funct3E == c_REM);
    assign w_a_neg    = w_a_signed && SrcAE[31];
    assign w_b_neg    = w_b_signed && SrcBE[31];
    assign w_mag_a    = w_a_neg ? (32'd0 - SrcAE) : SrcAE;
    assign w_mag_b    = w_b_neg ? (32'd0 - SrcBE) : SrcBE;

    assign w_div_zero = w_is_div && (SrcBE == 32'd0);
    assign w_div_ovf  = w_is_div && !Funct3E[0] && (SrcAE == 32'h8000_0000)
                        && (SrcBE == 32'hFFFF_FFFF);
    assign w_special  = w_div_zero || w_div_ovf;

    always_comb begin
        w_special_res = 32'd0;
        if (w_div_zero) begin
            w_special_res = Funct3E[1] ? SrcAE : 32'hFFFF_FFFF;
        end else if (w_div_ovf) begin
            w_special_res = Funct3E[1] ? 32'd0 : 32'h8000_0000;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] w_fast_mag;
    logic [63:0] w_fast_prod;

    assign w_fast      = !w_is_div;
    assign w_fast_mag  = {32'd0, w_mag_a} * {32'd0, w_mag_b};
    assign w_fast_prod = (w_a_neg ^ w_b_neg) ? (64'd0 - w_fast_mag) : w_fast_mag;
    assign w_fast_res  = (Funct3E == c_MUL) ? w_fast_prod[31:0] : w_fast_prod[63:32];
`else
    assign w_fast      = 1'b0;
    assign w_fast_res  = 32'd0;
`endif

    // -------------------------------------------------------------- datapath
    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_operand} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide: acc = {partial remainder, dividend shifting into quotient}.
    // trial < 2*divisor, so bit 32 of the difference is set only on borrow.
    assign w_trial    = r_acc[63:31];
    assign w_diff     = w_trial - {1'b0, r_operand};
    assign w_ge       = !w_diff[32];
    assign w_div_next = {(w_ge ? w_diff[31:0] : w_trial[31:0]), r_acc[30:0], w_ge};

    assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;

    assign w_prod = r_neg_q ? (64'd0 - w_acc_next) : w_acc_next;
    assign w_quot = r_neg_q ? (32'd0 - w_acc_next[31:0]) : w_acc_next[31:0];
    assign w_rem  = r_neg_r ? (32'd0 - w_acc_next[63:32]) : w_acc_next[63:32];

    always_comb begin
        w_final = 32'd0;
        case (r_op)
            3'd0:          w_final = w_prod[31:0];
            3'd1, 3'd2,
            3'd3:          w_final = w_prod[63:32];
            3'd4, 3'd5:    w_final = w_quot;
            default:       w_final = w_rem;
        endcase
    end

    // ------------------------------------------------------------------- FSM
    always_comb begin
        w_state_next = r_state;
        if (FlushE) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (StartE) begin
                        w_state_next = (w_special || w_fast) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_count == 5'd31) begin
                        w_state_next = S_DONE;
                    end
                end
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_count   <= 5'd0;
            r_op      <= 3'd0;
            r_operand <= 32'd0;
            r_acc     <= 64'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= 32'd0;
            r_rd      <= 5'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op    <= Funct3E;
                r_rd    <= RdE;
                r_count <= 5'd0;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                if (w_is_div) begin
                    r_operand <= w_mag_b;
                    r_acc     <= {32'd0, w_mag_a};
                end else begin
                    r_operand <= w_mag_a;
                    r_acc     <= {32'd0, w_mag_b};
                end
                if (w_special) begin
                    r_result <= w_special_res;
                end else if (w_fast) begin
                    r_result <= w_fast_res;
                end
            end else if (r_state == S_RUN) begin
                if (FlushE) begin
                    r_count <= 5'd0;
                end else begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_result <= w_final;
                    end
                end
            end
        end
    end

    // Gated by reset so a held StartE cannot request a stall during reset.
    assign StallE  = reset && ((r_state == S_RUN) || w_accept);
    assign DoneE   = (r_state == S_DONE);
    assign ResultE = r_result;
    assign RdOutE  = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed self-checking bench for muldiv_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        FlushE;
    logic        StartE;
    logic [2:0]  Funct3E;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [4:0]  RdE;
    logic        StallE;
    logic        DoneE;
    logic [31:0] ResultE;
    logic [4:0]  RdOutE;

    int checks   = 0;
    int failures = 0;

    muldiv_unit dut (
        .clk     (clk),
        .reset   (reset),
        .FlushE  (FlushE),
        .StartE  (StartE),
        .Funct3E (Funct3E),
        .SrcAE   (SrcAE),
        .SrcBE   (SrcBE),
        .RdE     (RdE),
        .StallE  (StallE),
        .DoneE   (DoneE),
        .ResultE (ResultE),
        .RdOutE  (RdOutE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one op, waits (bounded) for DoneE, checks latency, stall length,
    // result, destination, and that the result holds after the DONE cycle.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int cyc;
        int stalls;
        @(negedge clk);
        StartE  = 1'b1;
        Funct3E = f3;
        SrcAE   = a;
        SrcBE   = b;
        RdE     = rd;
        #1;
        cyc    = 1;
        stalls = StallE ? 1 : 0;
        @(negedge clk);
        StartE = 1'b0;
        SrcAE  = ~a;
        SrcBE  = ~b;
        RdE    = ~rd;
        cyc    = 2;
        while (!DoneE && cyc < 200) begin
            if (StallE) stalls++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"},    cyc,     exp_lat);
        chk({tag, "_stalls"}, stalls,  exp_lat - 1);
        chk({tag, "_result"}, ResultE, exp);
        chk({tag, "_rd"},     RdOutE,  {27'd0, rd});
        chk({tag, "_stall_done"}, StallE, 1'b0);
        @(negedge clk);
        chk({tag, "_done_clr"}, DoneE,   1'b0);
        chk({tag, "_hold"},     ResultE, exp);
    endtask

    initial begin
        int seen;
        reset   = 1'b0;
        FlushE  = 1'b0;
        StartE  = 1'b1;
        Funct3E = 3'd4;
        SrcAE   = 32'd5;
        SrcBE   = 32'd1;
        RdE     = 5'd1;
        #12;
        chk("rst_stall",  StallE,  1'b0);
        chk("rst_done",   DoneE,   1'b0);
        chk("rst_result", ResultE, 32'd0);
        chk("rst_rd",     RdOutE,  5'd0);
        @(negedge clk);
        StartE = 1'b0;
        reset  = 1'b1;

        run_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2,          5'd3,  32'hFFFF_FFFD, 34);
        run_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2,          5'd4,  32'hFFFF_FFFF, 34);
        run_op("div_7_m2",   3'd4, 32'd7,         32'hFFFF_FFFE,  5'd5,  32'hFFFF_FFFD, 34);
        run_op("rem_7_m2",   3'd6, 32'd7,         32'hFFFF_FFFE,  5'd6,  32'd1,         34);
        run_op("divu_100_7", 3'd5, 32'd100,       32'd7,          5'd7,  32'd14,        34);
        run_op("remu_100_7", 3'd7, 32'd100,       32'd7,          5'd8,  32'd2,         34);
        run_op("divu_by0",   3'd5, 32'h0000_1234, 32'd0,          5'd9,  32'hFFFF_FFFF, 2);
        run_op("remu_by0",   3'd7, 32'h0000_1234, 32'd0,          5'd10, 32'h0000_1234, 2);
        run_op("div_by0",    3'd4, 32'hFFFF_FFFB, 32'd0,          5'd11, 32'hFFFF_FFFF, 2);
        run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF,  5'd12, 32'h8000_0000, 2);
        run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF,  5'd13, 32'd0,         2);
        run_op("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000,  5'd14, 32'h4000_0000, MUL_LAT);
        run_op("mulhsu_m1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5'd15, 32'hFFFF_FFFF, MUL_LAT);
        run_op("mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5'd16, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mul_7_m3",   3'd0, 32'd7,         32'hFFFF_FFFD,  5'd17, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulhu_x2",   3'd3, 32'hFFFF_FFFF, 32'd2,          5'd18, 32'h0000_0001, MUL_LAT);

        // Flush while RUN is at count 10.
        @(negedge clk);
        StartE  = 1'b1;
        Funct3E = 3'd4;
        SrcAE   = 32'd1000;
        SrcBE   = 32'd3;
        RdE     = 5'd19;
        @(negedge clk);
        StartE = 1'b0;
        repeat (10) @(negedge clk);
        chk("flush_stall_run", StallE, 1'b1);
        FlushE = 1'b1;
        @(negedge clk);
        FlushE = 1'b0;
        #1;
        chk("flush_stall_idle", StallE, 1'b0);
        chk("flush_done_idle",  DoneE,  1'b0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (DoneE) seen = 1;
        end
        chk("flush_no_done", seen, 0);
        run_op("div_after_flush", 3'd4, 32'd1000, 32'd3, 5'd20, 32'd333, 34);

        // Asynchronous reset in the middle of a RUN.
        @(negedge clk);
        StartE  = 1'b1;
        Funct3E = 3'd5;
        SrcAE   = 32'd100;
        SrcBE   = 32'd7;
        RdE     = 5'd21;
        @(negedge clk);
        StartE = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_result", ResultE, 32'd0);
        chk("arst_rd",     RdOutE,  5'd0);
        chk("arst_done",   DoneE,   1'b0);
        chk("arst_stall",  StallE,  1'b0);
        @(negedge clk);
        reset = 1'b1;
        seen  = 0;
        repeat (40) begin
            @(negedge clk);
            if (DoneE) seen = 1;
        end
        chk("arst_no_done", seen, 0);
        run_op("mul_after_rst", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd22, 32'hFFFF_FFEB, MUL_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
